sm4_cmd_seq: RTL and testbench

SM4_CMD_SEQ -- requirements
Module: sm4_cmd_seq

---
 rtl/sm4_pkg.sv | 26 ++
 rtl/sm4_cmd_seq.sv | 169 ++++++++++++++++
 tb/tb_sm4_cmd_seq.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm4_pkg.sv
// Shared encodings for the SM4 command sequencer: core command codes,
// sequencer states and the default completion timeout.
package sm4_pkg;

  localparam int TIMEOUT_DEFAULT = 64;

  localparam logic [1:0] CMD_PAUSE  = 2'b00;
  localparam logic [1:0] CMD_KEYEXP = 2'b01;
  localparam logic [1:0] CMD_ENC    = 2'b10;
  localparam logic [1:0] CMD_DEC    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_KEY_ISS  = 3'd1,
    ST_KEY_WAIT = 3'd2,
    ST_BLK_ISS  = 3'd3,
    ST_BLK_WAIT = 3'd4,
    ST_BLK_OUT  = 3'd5,
    ST_RESP     = 3'd6
  } seq_state_e;

  function automatic logic [1:0] blk_cmd(input logic dec);
    return dec ? CMD_DEC : CMD_ENC;
  endfunction

endpackage

// File: rtl/sm4_cmd_seq.sv
// Command sequencer sitting beside an SM4 core: turns user key/block requests
// into one-cycle core commands, tracks completion and returns results.
module sm4_cmd_seq
  import sm4_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_vld,
  input  logic [127:0] key_in,
  output logic         key_rdy,
  input  logic         blk_vld,
  input  logic [127:0] blk_din,
  input  logic         blk_dec,
  output logic         blk_rdy,
  output logic         res_vld,
  output logic [127:0] res_dout,
  input  logic         res_rdy,
  output logic         key_loaded,
  output logic         err,
  output logic [1:0]   core_cmd,
  output logic [127:0] core_din,
  input  logic         core_key_done,
  input  logic         core_enc_ok,
  input  logic [127:0] core_dout,
  output logic [2:0]   state_dbg
);

  // Handshakes: a transfer happens on a rising edge where vld and rdy are both
  // high; rdy never depends on a later cycle, and res_vld/res_dout stay put
  // until res_rdy is seen.

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  seq_state_e     state_q, state_d;
  logic [127:0]   din_q, din_d;
  logic           dec_q, dec_d;
  logic [127:0]   dout_q, dout_d;
  logic           vld_q, vld_d;
  logic           kl_q, kl_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           enc_ok_q;
  logic [1:0]     cmd_c;
  logic           ok_rise, ok_fall, tmo_hit;

  assign ok_rise = core_enc_ok & ~enc_ok_q;
  assign ok_fall = ~core_enc_ok & enc_ok_q;
  assign tmo_hit = (cnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    dec_d   = dec_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    kl_d    = kl_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    cmd_c   = CMD_PAUSE;
    case (state_q)
      ST_IDLE: begin
        // A key request outranks a block request presented in the same cycle.
        if (key_vld) begin
          din_d   = key_in;
          state_d = ST_KEY_ISS;
        end else if (blk_vld && kl_q) begin
          din_d   = blk_din;
          dec_d   = blk_dec;
          state_d = ST_BLK_ISS;
        end
      end
      ST_KEY_ISS: begin
        cmd_c   = CMD_KEYEXP;
        kl_d    = 1'b0;
        cnt_d   = '0;
        state_d = ST_KEY_WAIT;
      end
      ST_KEY_WAIT: begin
        if (core_key_done) begin
          kl_d    = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          kl_d    = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BLK_ISS: begin
        cmd_c   = blk_cmd(dec_q);
        cnt_d   = '0;
        state_d = ST_BLK_WAIT;
      end
      ST_BLK_WAIT: begin
        if (ok_rise) begin
          cnt_d   = '0;
          state_d = ST_BLK_OUT;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          kl_d    = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BLK_OUT: begin
        // Waiting for the falling edge means the core is idle again before
        // the next command can be issued.
        if (ok_fall) begin
          dout_d  = core_dout;
          vld_d   = 1'b1;
          state_d = ST_RESP;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          kl_d    = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (res_rdy) begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      din_q    <= '0;
      dec_q    <= 1'b0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      kl_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      enc_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      dec_q    <= dec_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
      kl_q     <= kl_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      enc_ok_q <= core_enc_ok;
    end
  end

  assign key_rdy    = (state_q == ST_IDLE);
  assign blk_rdy    = (state_q == ST_IDLE) & kl_q & ~key_vld;
  assign res_vld    = vld_q;
  assign res_dout   = dout_q;
  assign key_loaded = kl_q;
  assign err        = err_q;
  assign core_cmd   = cmd_c;
  assign core_din   = din_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_sm4_cmd_seq.sv
// Bench for sm4_cmd_seq: SM4 core stub, transaction-level reference model with
// an expected-result queue checked every cycle, and directed scenarios.
module tb_sm4_cmd_seq;
  import sm4_pkg::*;

  localparam int TMO     = 64;
  localparam int KEY_LAT = 3;
  localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_vld = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_rdy;
  logic         blk_vld = 1'b0;
  logic [127:0] blk_din = '0;
  logic         blk_dec = 1'b0;
  logic         blk_rdy;
  logic         res_vld;
  logic [127:0] res_dout;
  logic         res_rdy = 1'b0;
  logic         key_loaded;
  logic         err;
  logic [1:0]   core_cmd;
  logic [127:0] core_din;
  logic         core_key_done = 1'b0;
  logic         core_enc_ok = 1'b0;
  logic [127:0] core_dout = '0;
  logic [2:0]   state_dbg;

  int checks = 0;
  int failures = 0;
  logic [127:0] exp_q[$];

  sm4_cmd_seq #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .key_vld(key_vld), .key_in(key_in), .key_rdy(key_rdy),
    .blk_vld(blk_vld), .blk_din(blk_din), .blk_dec(blk_dec), .blk_rdy(blk_rdy),
    .res_vld(res_vld), .res_dout(res_dout), .res_rdy(res_rdy),
    .key_loaded(key_loaded), .err(err),
    .core_cmd(core_cmd), .core_din(core_din),
    .core_key_done(core_key_done), .core_enc_ok(core_enc_ok), .core_dout(core_dout),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // What the SM4 core returns: the known test vectors, anything else gets a
  // fixed reversible scramble so routing of distinct blocks stays visible.
  function automatic logic [127:0] core_ref(input logic [127:0] d, input logic dec);
    if (!dec && d == PT) return CT;
    if (dec && d == CT) return PT;
    if (dec) return d ^ {4{32'h5a5aa5a5}};
    return {d[63:0], d[127:64]} ^ {4{32'h0f1e2d3c}};
  endfunction

  // ---------------- core stub ----------------
  logic [1:0]   s_cmd = CMD_PAUSE;
  logic [127:0] s_din = '0;
  logic         s_rst = 1'b1;
  logic [127:0] s_res = '0;
  int  blk_t = 0;
  int  key_t = 0;
  int  s_l1 = 3;
  int  s_h = 2;
  bit  s_hang = 1'b0;

  initial forever begin
    @(negedge clk);
    s_cmd = core_cmd;
    s_din = core_din;
    s_rst = rst;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (s_rst) begin
      blk_t = 0;
      key_t = 0;
    end else begin
      if (s_cmd == CMD_KEYEXP) key_t = 1;
      else if (key_t > 0) key_t++;
      if (s_cmd == CMD_ENC || s_cmd == CMD_DEC) begin
        blk_t = 1;
        s_res = core_ref(s_din, s_cmd == CMD_DEC);
      end else if (blk_t > 0) begin
        blk_t++;
      end
    end
    core_key_done = (key_t == KEY_LAT);
    core_enc_ok   = !s_hang && blk_t >= s_l1 && blk_t < s_l1 + s_h;
    core_dout     = (blk_t >= s_l1 + s_h) ? s_res : ~s_res;
  end

  // ---------------- reference model + per-cycle compare ----------------
  typedef enum int {M_FREE, M_CMD, M_WAIT, M_HOLD} m_phase_e;
  typedef enum int {W_KEY, W_RISE, W_FALL} m_want_e;
  m_phase_e     m_phase = M_FREE;
  m_want_e      m_want = W_KEY;
  int           m_waited = 0;
  bit           m_is_key = 1'b0;
  logic         m_kl = 1'b0, m_vld = 1'b0, m_err = 1'b0, m_prev = 1'b0;
  logic [1:0]   m_cmd = CMD_PAUSE;
  logic [127:0] m_din = '0, m_dout = '0;

  initial forever begin
    bit hit;
    @(negedge clk);
    chk("key_rdy", key_rdy, m_phase == M_FREE);
    chk("blk_rdy", blk_rdy, (m_phase == M_FREE) && m_kl && !key_vld);
    chk("res_vld", res_vld, m_vld);
    chk("res_dout", res_dout, m_dout);
    chk("key_loaded", key_loaded, m_kl);
    chk("err", err, m_err);
    chk("core_cmd", core_cmd, m_cmd);
    chk("core_din", core_din, m_din);
    if (rst) begin
      m_phase = M_FREE; m_kl = 1'b0; m_vld = 1'b0; m_err = 1'b0; m_prev = 1'b0;
      m_cmd = CMD_PAUSE; m_din = '0; m_dout = '0;
      exp_q.delete();
    end else begin
      m_err = 1'b0;
      m_cmd = CMD_PAUSE;
      case (m_phase)
        M_FREE: begin
          if (key_vld) begin
            m_din = key_in; m_cmd = CMD_KEYEXP; m_is_key = 1'b1; m_phase = M_CMD;
          end else if (blk_vld && m_kl) begin
            m_din = blk_din; m_cmd = blk_dec ? CMD_DEC : CMD_ENC; m_is_key = 1'b0;
            exp_q.push_back(core_ref(blk_din, blk_dec));
            m_phase = M_CMD;
          end
        end
        M_CMD: begin
          m_phase = M_WAIT; m_waited = 0;
          m_want = m_is_key ? W_KEY : W_RISE;
          if (m_is_key) m_kl = 1'b0;
        end
        M_WAIT: begin
          hit = (m_want == W_KEY && core_key_done) ||
                (m_want == W_RISE && core_enc_ok && !m_prev) ||
                (m_want == W_FALL && !core_enc_ok && m_prev);
          if (hit) begin
            if (m_want == W_KEY) begin
              m_kl = 1'b1; m_phase = M_FREE;
            end else if (m_want == W_RISE) begin
              m_want = W_FALL; m_waited = 0;
            end else if (exp_q.size() > 0) begin
              m_dout = exp_q.pop_front(); m_vld = 1'b1; m_phase = M_HOLD;
            end else begin
              checks++; failures++;
              $display("FAIL exp_q_empty actual=0 required=1");
              m_phase = M_HOLD; m_vld = 1'b1;
            end
          end else if (m_waited == TMO - 1) begin
            m_err = 1'b1; m_kl = 1'b0; m_phase = M_FREE;
            if (!m_is_key && exp_q.size() > 0) exp_q.delete(0);
          end else begin
            m_waited++;
          end
        end
        M_HOLD: if (res_rdy) begin m_vld = 1'b0; m_phase = M_FREE; end
        default: m_phase = M_FREE;
      endcase
      m_prev = core_enc_ok;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [127:0] k);
    bit hs = 1'b0;
    key_vld = 1'b1;
    key_in  = k;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk);
      hs = key_rdy;
      step();
    end
    key_vld = 1'b0;
    chk("key_handshake", hs, 1'b1);
  endtask

  task automatic send_blk(input logic [127:0] d, input logic dec);
    bit hs = 1'b0;
    blk_vld = 1'b1;
    blk_din = d;
    blk_dec = dec;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk);
      hs = blk_rdy;
      step();
    end
    blk_vld = 1'b0;
    chk("blk_handshake", hs, 1'b1);
  endtask

  task automatic get_result(input logic [127:0] e, input int hold, input bit poke, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = res_vld;
      if (!seen) step();
    end
    chk({name, "_res_vld_seen"}, seen, 1'b1);
    if (seen) begin
      chk({name, "_dout"}, res_dout, e);
      step();
      if (poke) begin
        blk_vld = 1'b1;
        blk_din = 128'hfeedface_00000000_11111111_22222222;
      end
      repeat (hold) step();
      @(negedge clk);
      chk({name, "_dout_held"}, res_dout, e);
      chk({name, "_vld_held"}, res_vld, 1'b1);
      step();
      blk_vld = 1'b0;
      res_rdy = 1'b1;
      step();
      res_rdy = 1'b0;
      @(negedge clk);
      chk({name, "_idle_after"}, state_dbg, ST_IDLE);
      chk({name, "_vld_dropped"}, res_vld, 1'b0);
      step();
    end
  endtask

  task automatic wait_err(input string name, input int exp_cycle);
    int k = 0;
    bit got = 1'b0;
    for (int i = 1; i <= 300 && !got; i++) begin
      @(negedge clk);
      if (err) begin got = 1'b1; k = i; end
    end
    chk({name, "_err_seen"}, got, 1'b1);
    chk({name, "_err_cycle"}, k, exp_cycle);
    chk({name, "_key_loaded"}, key_loaded, 1'b0);
    chk({name, "_res_vld"}, res_vld, 1'b0);
    step();
    @(negedge clk);
    chk({name, "_err_width"}, err, 1'b0);
    step();
  endtask

  // ---------------- directed scenarios ----------------
  logic [127:0] vec_din [4];
  logic         vec_dec [4];

  initial begin
    vec_din[0] = 128'h00112233445566778899aabbccddeeff; vec_dec[0] = 1'b0;
    vec_din[1] = 128'hffffffff000000005555555533333333; vec_dec[1] = 1'b1;
    vec_din[2] = 128'h0;                               vec_dec[2] = 1'b0;
    vec_din[3] = CT;                                   vec_dec[3] = 1'b1;

    // reset values while rst is held
    repeat (3) step();
    @(negedge clk);
    chk("rst_key_loaded", key_loaded, 1'b0);
    chk("rst_res_vld", res_vld, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_core_cmd", core_cmd, CMD_PAUSE);
    chk("rst_core_din", core_din, 128'h0);
    chk("rst_res_dout", res_dout, 128'h0);
    chk("rst_state", state_dbg, ST_IDLE);
    step();
    rst = 1'b0;

    // block request with no key: never accepted
    blk_vld = 1'b1; blk_din = PT; blk_dec = 1'b0;
    repeat (8) step();
    @(negedge clk);
    chk("nokey_blk_rdy", blk_rdy, 1'b0);
    chk("nokey_core_cmd", core_cmd, CMD_PAUSE);
    step();

    // key and block presented together: key goes first, then the block
    send_key(KEY);
    @(negedge clk);
    chk("key_first_cmd", core_cmd, CMD_KEYEXP);
    chk("key_first_din", core_din, KEY);
    step();
    send_blk(PT, 1'b0);
    chk("enc_key_loaded", key_loaded, 1'b1);
    get_result(CT, 0, 1'b0, "enc_vec");

    // decrypt with a 20-cycle stall on res_rdy and a pending block request
    send_blk(CT, 1'b1);
    get_result(PT, 20, 1'b1, "dec_vec");

    // assorted blocks with varying core latency and consumer stalls
    for (int v = 0; v < 4; v++) begin
      s_l1 = $urandom_range(2, 6);
      s_h  = $urandom_range(1, 4);
      send_blk(vec_din[v], vec_dec[v]);
      get_result(core_ref(vec_din[v], vec_dec[v]), $urandom_range(0, 3), 1'b0, "mix");
    end

    // core never raises enc_ok: err 64 cycles after BLK_WAIT entry
    s_l1 = 3; s_h = 2; s_hang = 1'b1;
    send_blk(128'hdeadbeef_cafef00d_01234567_89abcdef, 1'b0);
    wait_err("tmo_wait", 66);
    s_hang = 1'b0;

    // enc_ok rises but never falls: timeout restarts on BLK_OUT entry
    send_key(KEY);
    s_h = 1000;
    send_blk(PT, 1'b0);
    wait_err("tmo_out", 69);
    repeat (1100) step();
    s_h = 2;

    // completion on the very last allowed cycle wins over the timeout
    send_key(KEY);
    s_l1 = 64;
    send_blk(CT, 1'b1);
    get_result(PT, 1, 1'b0, "edge_win");
    s_l1 = 3;

    // reset while waiting in BLK_WAIT abandons the operation
    s_l1 = 20;
    send_blk(PT, 1'b0);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_res_vld", res_vld, 1'b0);
    chk("midrst_err", err, 1'b0);
    chk("midrst_key_loaded", key_loaded, 1'b0);
    chk("midrst_core_cmd", core_cmd, CMD_PAUSE);
    chk("midrst_core_din", core_din, 128'h0);
    chk("midrst_res_dout", res_dout, 128'h0);
    chk("midrst_state", state_dbg, ST_IDLE);
    step();
    repeat (30) step();
    s_l1 = 3;
    send_key(KEY);
    send_blk(PT, 1'b0);
    get_result(CT, 2, 1'b0, "post_rst");

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
